blake2_fifo_sched: RTL and testbench
====================================

# blake2_fifo_sched

Controller and arbiter for the shared `controller_fifo_stack` buffer in the BLAKE2 message path. Two word-producers (dbits wide) share the buffer's single write port under round-robin arbitration. A read scheduler pops rd_pkt-word packets from the buffer and presents them downstream on a valid/ready interface. The block keeps its own occupancy count, so it never writes when the buffer is full and never pops with fewer than rd_pkt words stored.

## Interface

Parameters:
- abits, 3, buffer address width; depth DEPTH = 2^abits words
- dbits, 2, word width
- rd_pkt, 2, words per popped packet; must satisfy 1 <= rd_pkt <= DEPTH

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 offers a word
- req0_data  in  dbits  requester 0 word
- req0_ready  out  1  requester 0 word accepted this cycle when valid & ready
- req1_valid  in  1  requester 1 offers a word
- req1_data  in  dbits  requester 1 word
- req1_ready  out  1  requester 1 word accepted this cycle when valid & ready
- fifo_wr  out  1  write strobe to the buffer
- fifo_din  out  dbits  write data to the buffer (granted requester's word)
- fifo_rd  out  1  pop strobe; pops one rd_pkt-word packet
- fifo_empty  in  1  buffer empty flag
- fifo_full  in  1  buffer full flag
- fifo_dout  in  dbits*rd_pkt  buffer packet output; valid the cycle after fifo_rd
- pkt_valid  out  1  registered packet available downstream
- pkt_data  out  dbits*rd_pkt  registered packet, fifo_dout captured unmodified
- pkt_ready  in  1  downstream accepts the packet when pkt_valid & pkt_ready
- level  out  abits+1  controller occupancy count, in words (0..DEPTH)
- err  out  1  sticky: fifo_empty was high in a POP cycle

## Operation

- Reset (reset=1 at an edge): level=0, FSM=IDLE, pkt_valid=0, pkt_data=0, err=0, RR pointer favours req0.
  - While reset is high, req*_ready, fifo_wr and fifo_rd are forced to 0.
  - The buffer must be reset in the same cycles; this block does not reset it.
- Write space: space = (level < DEPTH) & !fifo_full.
- Write arbitration (combinational grant):
  - Only one requester valid: it is granted.
  - Both valid: the pointer's favoured requester is granted.
  - reqX_ready = grantX & space. The non-granted requester's ready is 0.
  - fifo_wr = accept = granted valid & space. fifo_din = granted data.
- RR pointer update: on every accept, the pointer moves to favour the requester that was not served.
- Read FSM:
  - IDLE: if level >= rd_pkt and pkt_valid=0, go to POP.
  - POP: fifo_rd=1 for exactly one cycle; level is reduced by rd_pkt at this edge; go to LOAD.
  - LOAD: pkt_data <= fifo_dout; pkt_valid <= 1; go to HOLD.
  - HOLD: pkt_data is held stable while pkt_valid=1. When pkt_ready=1, pkt_valid <= 0 and go to IDLE.
  - Only one packet is ever in flight. No POP is issued while pkt_valid=1.
- Level arithmetic, width abits+1: level_next = level + accept - (fifo_rd ? rd_pkt : 0).
  - Simultaneous accept and POP is allowed and nets out in the same cycle.
  - Level never underflows (POP requires level >= rd_pkt) and never exceeds DEPTH (accept requires space).
- err is set when fifo_rd=1 and fifo_empty=1 in the same cycle. It clears only on reset.
- Reset mid-operation: at the reset edge, all state returns to reset values regardless of FSM state. An in-flight packet is discarded with no pkt_ready needed.

## Timing

- Write path is zero-latency: accept and fifo_wr occur in the same cycle as reqX_valid & reqX_ready. level updates at that edge.
- Pop latency: level reaches >= rd_pkt at edge N → FSM is in POP during cycle N+1 (fifo_rd=1) → LOAD during cycle N+2 → pkt_valid=1 from cycle N+3.
- Back-to-back packets: the earliest next POP is the cycle after the HOLD cycle in which pkt_ready=1 (IDLE for one cycle, then POP).
- Sustained read throughput is therefore one packet per 4 cycles with pkt_ready held high.
- All outputs except req*_ready, fifo_wr and fifo_din are registered.

## Test plan

- Reset: hold reset for 2 cycles with both valids high → req*_ready=0, fifo_wr=0, fifo_rd=0, pkt_valid=0, level=0, err=0 throughout; the first accept after reset goes to req0.
- Single-producer packet: req0 writes 1 then 2 on consecutive cycles, pkt_ready=1 → level goes 1, 2; fifo_rd pulses one cycle later; level=0; pkt_valid rises 2 cycles after the pulse with pkt_data = fifo_dout of that cycle; pkt_valid is high for 1 cycle.
- Round-robin fill: both valid continuously, req0_data=1, req1_data=3, pkt_ready=0, DEPTH=8, rd_pkt=2 → grants alternate 0,1,0,1,…; one POP occurs; level climbs to 8; both readies are then 0 and fifo_wr stays 0.
- Simultaneous write and pop: at level=3 with the FSM entering POP and req1 writing → level=2 after that edge (3+1-2).
- Backpressure: pkt_valid=1 and pkt_ready=0 for 5 cycles with level=6 → pkt_data constant, fifo_rd stays 0. After pkt_ready=1 for one cycle → IDLE, then POP on the next cycle.
- Reset during HOLD and empty-pop error: assert reset while pkt_valid=1 → pkt_valid=0 and level=0 next cycle. Separately, force fifo_empty=1 during a POP → err=1 and it stays 1 until reset.

Source files
------------

// File: rtl/blake2_fifo_sched.sv
// blake2_fifo_sched: round-robin write arbiter and packet pop scheduler for the shared BLAKE2 message buffer
module blake2_fifo_sched #(
  parameter int abits  = 3,
  parameter int dbits  = 2,
  parameter int rd_pkt = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0_valid,
  input  logic [dbits-1:0]        req0_data,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [dbits-1:0]        req1_data,
  output logic                    req1_ready,
  output logic                    fifo_wr,
  output logic [dbits-1:0]        fifo_din,
  output logic                    fifo_rd,
  input  logic                    fifo_empty,
  input  logic                    fifo_full,
  input  logic [dbits*rd_pkt-1:0] fifo_dout,
  output logic                    pkt_valid,
  output logic [dbits*rd_pkt-1:0] pkt_data,
  input  logic                    pkt_ready,
  output logic [abits:0]          level,
  output logic                    err
);
  localparam int DEPTH = 1 << abits;
  localparam int LW = abits + 1;
  typedef enum logic [1:0] {IDLE, POP, LOAD, HOLD} state_t;
  state_t                  state_q, state_d;
  logic [LW-1:0]           level_q, level_d;
  logic                    ptr_q, ptr_d;
  logic                    pkt_valid_q, pkt_valid_d;
  logic [dbits*rd_pkt-1:0] pkt_data_q, pkt_data_d;
  logic                    err_q, err_d;
  logic                    space, grant0, grant1, accept;
  // zero-latency write grant; ptr_q=1 favours req1 when both offer a word
  always_comb begin
    space      = (level_q < LW'(DEPTH)) && !fifo_full;
    grant1     = req1_valid && (!req0_valid || ptr_q);
    grant0     = req0_valid && !grant1;
    req0_ready = grant0 && space && !reset;
    req1_ready = grant1 && space && !reset;
    accept     = req0_ready || req1_ready;
    fifo_wr    = accept;
    fifo_din   = grant1 ? req1_data : req0_data;
    ptr_d      = accept ? grant0 : ptr_q;
  end
  // one-packet-in-flight pop sequencer plus occupancy and empty-pop tracking
  always_comb begin
    fifo_rd     = (state_q == POP) && !reset;
    state_d     = state_q;
    pkt_valid_d = pkt_valid_q;
    pkt_data_d  = pkt_data_q;
    level_d     = level_q + LW'(accept) - (fifo_rd ? LW'(rd_pkt) : '0);
    err_d       = err_q || (fifo_rd && fifo_empty);
    case (state_q)
      IDLE: state_d = (level_q >= LW'(rd_pkt) && !pkt_valid_q) ? POP : IDLE;
      POP:  state_d = LOAD;
      LOAD: begin
        pkt_data_d  = fifo_dout;
        pkt_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        pkt_valid_d = pkt_ready ? 1'b0 : 1'b1;
        state_d     = pkt_ready ? IDLE : HOLD;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset discards any in-flight packet
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      level_q     <= '0;
      ptr_q       <= 1'b0;
      pkt_valid_q <= 1'b0;
      pkt_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      ptr_q       <= ptr_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_data_q  <= pkt_data_d;
      err_q       <= err_d;
    end
  end
  assign pkt_valid = pkt_valid_q;
  assign pkt_data  = pkt_data_q;
  assign level     = level_q;
  assign err       = err_q;
endmodule

// File: tb/tb_blake2_fifo_sched.sv
// tb_blake2_fifo_sched: random and directed stimulus against a queue-based reference model
module tb_blake2_fifo_sched;
  logic       clk = 0, rst = 1;
  logic       v0 = 0, v1 = 0, pkt_ready = 0, force_full = 0, force_empty = 0;
  logic [1:0] d0 = 0, d1 = 0;
  logic       buf_full = 0, buf_empty = 1;
  logic [3:0] fifo_dout = 0;
  logic       fifo_full, fifo_empty;
  logic       req0_ready, req1_ready, fifo_wr, fifo_rd, pkt_valid, err;
  logic [1:0] fifo_din;
  logic [3:0] pkt_data;
  logic [3:0] level;
  int         errors = 0, checks = 0;
  assign fifo_full  = force_full | buf_full;
  assign fifo_empty = force_empty | buf_empty;
  always #5 clk = ~clk;

  blake2_fifo_sched #(.abits(3), .dbits(2), .rd_pkt(2)) dut (
    .clk(clk), .reset(rst),
    .req0_valid(v0), .req0_data(d0), .req0_ready(req0_ready),
    .req1_valid(v1), .req1_data(d1), .req1_ready(req1_ready),
    .fifo_wr(fifo_wr), .fifo_din(fifo_din), .fifo_rd(fifo_rd),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_dout(fifo_dout),
    .pkt_valid(pkt_valid), .pkt_data(pkt_data), .pkt_ready(pkt_ready),
    .level(level), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // buffer stand-in: stores words, pops two per strobe, first word in the low bits
  logic [1:0] bq[$];
  logic [1:0] bw0, bw1;
  always @(posedge clk) begin
    if (rst) begin
      bq.delete();
      fifo_dout <= 0;
      buf_full  <= 0;
      buf_empty <= 1;
    end else begin
      if (fifo_rd && bq.size() >= 2) begin
        bw0 = bq.pop_front();
        bw1 = bq.pop_front();
        fifo_dout <= {bw1, bw0};
      end
      if (fifo_wr) bq.push_back(fifo_din);
      buf_full  <= (bq.size() == 8);
      buf_empty <= (bq.size() == 0);
    end
  end

  // reference model: word count, favoured requester, pending pop/load and the presented packet
  int         m_level = 0;
  bit         m_fav = 0, m_pop = 0, m_load = 0, m_valid = 0, m_err = 0;
  logic [3:0] m_data = 0, m_cap = 0;
  logic [1:0] mq[$];
  bit         m_space, m_g0, m_g1, e_r0, e_r1, e_wr, e_rd, m_idle;
  logic [1:0] e_din, mw0, mw1;
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      #2;
      m_space = (m_level < 8) && !fifo_full;
      m_g1 = v1 && (!v0 || m_fav);
      m_g0 = v0 && !m_g1;
      e_r0 = !rst && m_space && m_g0;
      e_r1 = !rst && m_space && m_g1;
      e_wr = e_r0 || e_r1;
      e_din = m_g1 ? d1 : d0;
      e_rd = !rst && m_pop;
      chk("req0_ready", req0_ready, e_r0);
      chk("req1_ready", req1_ready, e_r1);
      chk("fifo_wr", fifo_wr, e_wr);
      if (e_wr) chk("fifo_din", fifo_din, e_din);
      chk("fifo_rd", fifo_rd, e_rd);
      chk("pkt_valid", pkt_valid, m_valid);
      chk("pkt_data", pkt_data, m_data);
      chk("level", level, m_level);
      chk("err", err, m_err);
      if (rst) begin
        m_level = 0; m_fav = 0; m_pop = 0; m_load = 0; m_valid = 0; m_data = 0; m_err = 0;
        mq.delete();
      end else begin
        m_idle = !m_pop && !m_load && !m_valid;
        if (m_pop) begin
          mw0 = mq.pop_front();
          mw1 = mq.pop_front();
          m_cap = {mw1, mw0};
          m_err = m_err || fifo_empty;
          m_pop = 0;
          m_load = 1;
        end else if (m_load) begin
          m_valid = 1;
          m_data = m_cap;
          m_load = 0;
        end else if (m_valid && pkt_ready) begin
          m_valid = 0;
        end else if (m_idle && m_level >= 2) begin
          m_pop = 1;
        end
        m_level = m_level + (e_wr ? 1 : 0) - (e_rd ? 2 : 0);
        if (e_wr) begin
          mq.push_back(e_din);
          m_fav = m_g0;
        end
      end
    end
  end

  initial begin
    v0 = 1; v1 = 1; d0 = 1; d1 = 3; rst = 1;
    repeat (2) @(negedge clk);
    rst = 0; v1 = 0; d0 = 1; pkt_ready = 1;
    @(negedge clk);
    d0 = 2;
    @(negedge clk);
    v0 = 0;
    chk("sp_level2", level, 2);
    for (int i = 0; i < 10 && !pkt_valid; i++) @(negedge clk);
    chk("sp_pkt_valid", pkt_valid, 1);
    chk("sp_pkt_data", pkt_data, 9);
    chk("sp_level0", level, 0);
    @(negedge clk);
    chk("sp_pulse", pkt_valid, 0);
    rst = 1;
    @(negedge clk);
    rst = 0; pkt_ready = 0; v0 = 1; v1 = 1; d0 = 1; d1 = 3;
    repeat (14) @(negedge clk);
    chk("rr_level", level, 8);
    chk("rr_pkt_data", pkt_data, 13);
    chk("rr_ready0", req0_ready, 0);
    chk("rr_ready1", req1_ready, 0);
    chk("rr_wr", fifo_wr, 0);
    v0 = 0; v1 = 0;
    repeat (5) @(negedge clk);
    chk("bp_data", pkt_data, 13);
    chk("bp_rd", fifo_rd, 0);
    pkt_ready = 1;
    repeat (8) @(negedge clk);
    pkt_ready = 0; v0 = 1; d0 = 2;
    repeat (8) @(negedge clk);
    chk("hold_valid", pkt_valid, 1);
    rst = 1;
    @(negedge clk);
    rst = 0; v0 = 0;
    chk("rst_hold_valid", pkt_valid, 0);
    chk("rst_hold_level", level, 0);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(99) == 0);
      v0 = $urandom_range(1);
      v1 = $urandom_range(1);
      d0 = 2'($urandom);
      d1 = 2'($urandom);
      pkt_ready = ($urandom_range(2) != 0);
      force_full = ($urandom_range(9) == 0);
      force_empty = ($urandom_range(19) == 0);
    end
    @(negedge clk);
    rst = 1; force_full = 0; force_empty = 0; v0 = 0; v1 = 0;
    @(negedge clk);
    rst = 0; v0 = 1; d0 = 2'($urandom); force_empty = 1; pkt_ready = 1;
    repeat (10) @(negedge clk);
    v0 = 0; force_empty = 0;
    repeat (3) @(negedge clk);
    chk("err_set", err, 1);
    repeat (10) @(negedge clk);
    chk("err_sticky", err, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("err_cleared", err, 0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
